// File: rtl/sdr_reply_pkg.sv
// Shared constants, state encoding and reply-code helper for the port-1024 reply transmitter.
package sdr_reply_pkg;

    localparam int unsigned REPLY_LEN_DEFAULT = 60;

    localparam logic [7:0] RC_DISC_IDLE = 8'h02;
    localparam logic [7:0] RC_DISC_RUN  = 8'h03;
    localparam logic [7:0] RC_ERASE     = 8'h04;
    localparam logic [7:0] RC_MORE      = 8'h05;

    localparam logic [5:0] OFS_SEQ   = 6'd0;
    localparam logic [5:0] OFS_CODE  = 6'd4;
    localparam logic [5:0] OFS_MAC   = 6'd5;
    localparam logic [5:0] OFS_BOARD = 6'd11;
    localparam logic [5:0] OFS_SKEW  = 6'd20;

    // Bit positions of each request in the req/ack/pending/served vectors.
    localparam int unsigned REQ_DISC  = 0;
    localparam int unsigned REQ_MORE  = 1;
    localparam int unsigned REQ_ERASE = 2;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StSend,
        StDone
    } state_e;

    function automatic logic [7:0] reply_code(input logic [2:0] served, input logic run_bit);
        if (served[REQ_ERASE]) begin
            return RC_ERASE;
        end else if (served[REQ_MORE]) begin
            return RC_MORE;
        end else begin
            return run_bit ? RC_DISC_RUN : RC_DISC_IDLE;
        end
    endfunction

endpackage

// File: rtl/sdr_reply_arb.sv
// Request capture for the reply transmitter: edge detect, pending flags, ACK pulses and
// fixed-priority selection (erase > send_more > discovery) of the request to serve.
module sdr_reply_arb
    import sdr_reply_pkg::*;
(
    input  logic        tx_clock,
    input  logic        reset_n,
    input  logic [2:0]  req,
    input  logic [31:0] sequence_number,
    input  logic        start,
    input  logic        done,
    output logic [2:0]  ack,
    output logic        any_pending,
    output logic [2:0]  served,
    output logic [31:0] seq_snap
);

    logic [2:0]  req_q;
    logic [2:0]  ack_q;
    logic [2:0]  pending_q;
    logic [2:0]  pending_d;
    logic [2:0]  served_q;
    logic [2:0]  rise;
    logic [2:0]  sel;
    logic [31:0] seq_q;

    always_comb begin
        rise = req & ~req_q;
        sel  = 3'b000;
        if (pending_q[REQ_ERASE]) begin
            sel[REQ_ERASE] = 1'b1;
        end else if (pending_q[REQ_MORE]) begin
            sel[REQ_MORE] = 1'b1;
        end else if (pending_q[REQ_DISC]) begin
            sel[REQ_DISC] = 1'b1;
        end
        // A fresh edge on the request being retired wins over the clear.
        pending_d = (pending_q & ~(done ? served_q : 3'b000)) | rise;
    end

    always_ff @(posedge tx_clock or negedge reset_n) begin
        if (!reset_n) begin
            req_q     <= 3'b000;
            ack_q     <= 3'b000;
            pending_q <= 3'b000;
            served_q  <= 3'b000;
            seq_q     <= 32'h0;
        end else begin
            req_q     <= req;
            ack_q     <= rise;
            pending_q <= pending_d;
            if (start) begin
                served_q <= sel;
            end
            if (rise[REQ_ERASE] || rise[REQ_MORE]) begin
                seq_q <= sequence_number;
            end
        end
    end

    assign ack         = ack_q;
    assign any_pending = |pending_q;
    assign served      = served_q;
    assign seq_snap    = seq_q;

endmodule

// File: rtl/sdr_reply_send.sv
// Builds and serialises 60-byte UDP replies (discovery, erase done, send more).
// Define SKEW_REPORT_EN to add the skew/phase inputs reported in discovery bytes 20-24.
module sdr_reply_send
    import sdr_reply_pkg::*;
#(
    parameter logic [7:0]  BOARD_ID      = 8'h05,
    parameter logic [7:0]  PROTOCOL_VER  = 8'd38,
    parameter logic [7:0]  FW_VERSION    = 8'd10,
    parameter int unsigned REPLY_LEN     = REPLY_LEN_DEFAULT,
    parameter int unsigned GRANT_TIMEOUT = 1250000
) (
    input  logic        tx_clock,
    input  logic        reset_n,
    input  logic        discovery_reply,
    input  logic        erase_done,
    input  logic        send_more,
    input  logic [31:0] sequence_number,
    input  logic [47:0] local_mac,
    input  logic        run,
`ifdef SKEW_REPORT_EN
    input  logic [7:0]  skew_rxtxc,
    input  logic [7:0]  skew_rxtxd,
    input  logic [10:0] skew_rxtxclk21,
    input  logic [7:0]  phaseval,
`endif
    input  logic        udp_tx_enable,
    output logic        udp_tx_request,
    output logic [15:0] udp_tx_length,
    output logic [7:0]  udp_tx_data,
    output logic        udp_tx_active,
    output logic        sending_sync,
    output logic        discovery_ACK,
    output logic        erase_ACK,
    output logic        send_more_ACK
);

    localparam int unsigned TW = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
    localparam logic [5:0]  LAST_IDX = 6'(REPLY_LEN - 1);

    state_e        state_q;
    state_e        state_d;
    logic [5:0]    idx_q;
    logic [TW-1:0] timer_q;
    logic [47:0]   mac_q;
    logic          run_q;
    logic [2:0]    req;
    logic [2:0]    ack;
    logic [2:0]    served;
    logic [31:0]   seq_snap;
    logic          any_pending;
    logic          start;
    logic          done;
    logic          disc;
    logic [7:0]    pkt_byte;

`ifdef SKEW_REPORT_EN
    logic [7:0]    skew_c_q;
    logic [7:0]    skew_d_q;
    logic [9:0]    skew_clk_q;
    logic [7:0]    phase_q;
    logic          unused_skew_msb;

    // Only the low ten bits of the clock skew are reported.
    assign unused_skew_msb = skew_rxtxclk21[10];
`endif

    assign req[REQ_DISC]  = discovery_reply;
    assign req[REQ_MORE]  = send_more;
    assign req[REQ_ERASE] = erase_done;

    assign start = (state_q == StIdle) && any_pending;
    assign done  = (state_q == StDone);

    sdr_reply_arb u_arb (
        .tx_clock        (tx_clock),
        .reset_n         (reset_n),
        .req             (req),
        .sequence_number (sequence_number),
        .start           (start),
        .done            (done),
        .ack             (ack),
        .any_pending     (any_pending),
        .served          (served),
        .seq_snap        (seq_snap)
    );

    always_ff @(posedge tx_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge tx_clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_q   <= 6'd0;
            timer_q <= '0;
            mac_q   <= 48'h0;
            run_q   <= 1'b0;
`ifdef SKEW_REPORT_EN
            skew_c_q   <= 8'h0;
            skew_d_q   <= 8'h0;
            skew_clk_q <= 10'h0;
            phase_q    <= 8'h0;
`endif
        end else begin
            if (state_q == StReq) begin
                idx_q   <= 6'd0;
                timer_q <= timer_q + 1'b1;
            end else begin
                timer_q <= '0;
                if (state_q == StSend) begin
                    idx_q <= idx_q + 6'd1;
                end
            end
            if (start) begin
                mac_q <= local_mac;
                run_q <= run;
`ifdef SKEW_REPORT_EN
                skew_c_q   <= skew_rxtxc;
                skew_d_q   <= skew_rxtxd;
                skew_clk_q <= skew_rxtxclk21[9:0];
                phase_q    <= phaseval;
`endif
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (any_pending) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (udp_tx_enable) begin
                    state_d = StSend;
                end else if (timer_q == TW'(GRANT_TIMEOUT - 1)) begin
                    state_d = StDone;
                end
            end
            StSend: begin
                // Loss of grant mid-packet drops the packet; it is never retried.
                if (!udp_tx_enable || (idx_q == LAST_IDX)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign disc = served[REQ_DISC];

    always_comb begin
        pkt_byte = 8'h00;
        case (idx_q)
            OFS_SEQ:           pkt_byte = disc ? 8'h00 : seq_snap[31:24];
            OFS_SEQ + 6'd1:    pkt_byte = disc ? 8'h00 : seq_snap[23:16];
            OFS_SEQ + 6'd2:    pkt_byte = disc ? 8'h00 : seq_snap[15:8];
            OFS_SEQ + 6'd3:    pkt_byte = disc ? 8'h00 : seq_snap[7:0];
            OFS_CODE:          pkt_byte = reply_code(served, run_q);
            OFS_MAC:           pkt_byte = mac_q[47:40];
            OFS_MAC + 6'd1:    pkt_byte = mac_q[39:32];
            OFS_MAC + 6'd2:    pkt_byte = mac_q[31:24];
            OFS_MAC + 6'd3:    pkt_byte = mac_q[23:16];
            OFS_MAC + 6'd4:    pkt_byte = mac_q[15:8];
            OFS_MAC + 6'd5:    pkt_byte = mac_q[7:0];
            OFS_BOARD:         pkt_byte = BOARD_ID;
            OFS_BOARD + 6'd1:  pkt_byte = PROTOCOL_VER;
            OFS_BOARD + 6'd2:  pkt_byte = FW_VERSION;
`ifdef SKEW_REPORT_EN
            OFS_SKEW:          pkt_byte = disc ? skew_c_q : 8'h00;
            OFS_SKEW + 6'd1:   pkt_byte = disc ? skew_d_q : 8'h00;
            OFS_SKEW + 6'd2:   pkt_byte = disc ? {3'b000, skew_clk_q[9:5]} : 8'h00;
            OFS_SKEW + 6'd3:   pkt_byte = disc ? {3'b000, skew_clk_q[4:0]} : 8'h00;
            OFS_SKEW + 6'd4:   pkt_byte = disc ? phase_q : 8'h00;
`endif
            default:           pkt_byte = 8'h00;
        endcase
    end

    always_comb begin
        udp_tx_request = (state_q == StReq);
        sending_sync   = (state_q == StReq) || (state_q == StSend);
        udp_tx_active  = (state_q == StSend);
        udp_tx_data    = (state_q == StSend) ? pkt_byte : 8'h00;
    end

    assign udp_tx_length = 16'(REPLY_LEN);
    assign discovery_ACK = ack[REQ_DISC];
    assign erase_ACK     = ack[REQ_ERASE];
    assign send_more_ACK = ack[REQ_MORE];

endmodule

// File: tb/tb_sdr_reply_send.sv
// Scoreboard bench for sdr_reply_send: stimulus queues expected bytes, a monitor checks them.
module tb_sdr_reply_send;

    localparam int unsigned TMO     = 20;
    localparam int          K_DISC  = 0;
    localparam int          K_MORE  = 1;
    localparam int          K_ERASE = 2;
`ifdef SKEW_REPORT_EN
    localparam bit SKEW = 1'b1;
`else
    localparam bit SKEW = 1'b0;
`endif

    logic        tx_clock = 1'b0;
    logic        reset_n;
    logic        discovery_reply;
    logic        erase_done;
    logic        send_more;
    logic [31:0] sequence_number;
    logic [47:0] local_mac;
    logic        run;
    logic [7:0]  skew_rxtxc;
    logic [7:0]  skew_rxtxd;
    logic [10:0] skew_rxtxclk21;
    logic [7:0]  phaseval;
    logic        udp_tx_enable;
    logic        udp_tx_request;
    logic [15:0] udp_tx_length;
    logic [7:0]  udp_tx_data;
    logic        udp_tx_active;
    logic        sending_sync;
    logic        discovery_ACK;
    logic        erase_ACK;
    logic        send_more_ACK;

    typedef struct {
        int         idx;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 tx_clock = ~tx_clock;

    sdr_reply_send #(
        .GRANT_TIMEOUT (TMO)
    ) dut (
        .tx_clock        (tx_clock),
        .reset_n         (reset_n),
        .discovery_reply (discovery_reply),
        .erase_done      (erase_done),
        .send_more       (send_more),
        .sequence_number (sequence_number),
        .local_mac       (local_mac),
        .run             (run),
`ifdef SKEW_REPORT_EN
        .skew_rxtxc      (skew_rxtxc),
        .skew_rxtxd      (skew_rxtxd),
        .skew_rxtxclk21  (skew_rxtxclk21),
        .phaseval        (phaseval),
`endif
        .udp_tx_enable   (udp_tx_enable),
        .udp_tx_request  (udp_tx_request),
        .udp_tx_length   (udp_tx_length),
        .udp_tx_data     (udp_tx_data),
        .udp_tx_active   (udp_tx_active),
        .sending_sync    (sending_sync),
        .discovery_ACK   (discovery_ACK),
        .erase_ACK       (erase_ACK),
        .send_more_ACK   (send_more_ACK)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int k, input int kind, input logic [31:0] seq,
                                            input logic run_v, input logic [47:0] mac);
        logic [7:0] b;
        b = 8'h00;
        if (k < 4) begin
            if (kind != K_DISC) b = 8'(seq >> (8 * (3 - k)));
        end else if (k == 4) begin
            if (kind == K_ERASE)     b = 8'h04;
            else if (kind == K_MORE) b = 8'h05;
            else                     b = run_v ? 8'h03 : 8'h02;
        end else if (k <= 10) begin
            b = 8'(mac >> (8 * (10 - k)));
        end else if (k == 11) begin
            b = 8'h05;
        end else if (k == 12) begin
            b = 8'h26;
        end else if (k == 13) begin
            b = 8'h0A;
        end else if (SKEW && kind == K_DISC) begin
            if (k == 20) b = skew_rxtxc;
            if (k == 21) b = skew_rxtxd;
            if (k == 22) b = {3'b000, skew_rxtxclk21[9:5]};
            if (k == 23) b = {3'b000, skew_rxtxclk21[4:0]};
            if (k == 24) b = phaseval;
        end
        return b;
    endfunction

    task automatic push_pkt(input int kind, input logic [31:0] seq, input logic run_v, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.idx = k;
            e.val = exp_byte(k, kind, seq, run_v, local_mac);
            exp_q.push_back(e);
        end
    endtask

    // Wait for the request, grant after 'delay' cycles, count bytes; optionally drop the
    // grant or assert reset once a given number of bytes has been seen.
    task automatic serve(input string name, input int delay, input int nbytes,
                         input int drop_at, input int rst_at);
        int waitc;
        int cnt;
        waitc = 0;
        while (!udp_tx_request && waitc < 20) begin
            @(negedge tx_clock);
            waitc++;
        end
        chk({name, "_req"}, 64'(udp_tx_request), 64'd1);
        if (!udp_tx_request) return;
        repeat (delay) @(negedge tx_clock);
        chk({name, "_sync"}, 64'(sending_sync), 64'd1);
        udp_tx_enable = 1'b1;
        @(negedge tx_clock);
        chk({name, "_latency"}, 64'(udp_tx_active), 64'd1);
        chk({name, "_req_drop"}, 64'(udp_tx_request), 64'd0);
        cnt = 0;
        while (udp_tx_active && cnt < 100) begin
            cnt++;
            if (cnt == drop_at) udp_tx_enable = 1'b0;
            if (cnt == rst_at) begin
                #2;
                reset_n = 1'b0;
                #1;
                chk({name, "_rst_active"}, 64'(udp_tx_active), 64'd0);
                chk({name, "_rst_sync"}, 64'(sending_sync), 64'd0);
                chk({name, "_rst_req"}, 64'(udp_tx_request), 64'd0);
                chk({name, "_rst_data"}, 64'(udp_tx_data), 64'd0);
                chk({name, "_rst_len"}, 64'(udp_tx_length), 64'd60);
                break;
            end
            @(negedge tx_clock);
        end
        udp_tx_enable = 1'b0;
        chk({name, "_bytes"}, 64'(cnt), 64'(nbytes));
        if (rst_at < 0) chk({name, "_sync_done"}, 64'(sending_sync), 64'd0);
    endtask

    task automatic quiet(input string name, input int n);
        int seen;
        seen = 0;
        repeat (n) begin
            @(negedge tx_clock);
            if (udp_tx_request || udp_tx_active) seen = 1;
        end
        chk(name, 64'(seen), 64'd0);
    endtask

    initial begin
        int cnt;
        reset_n         = 1'b0;
        discovery_reply = 1'b0;
        erase_done      = 1'b0;
        send_more       = 1'b0;
        sequence_number = 32'h0;
        local_mac       = 48'h001C_C0A2_13DD;
        run             = 1'b0;
        udp_tx_enable   = 1'b0;
        skew_rxtxc      = 8'h11;
        skew_rxtxd      = 8'h22;
        skew_rxtxclk21  = 11'h155;
        phaseval        = 8'h33;

        fork
            begin
                forever begin
                    exp_t e;
                    @(negedge tx_clock);
                    if (reset_n && udp_tx_active) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_byte: got byte %02h, required none", udp_tx_data);
                        end else begin
                            e = exp_q.pop_front();
                            chk($sformatf("byte%0d", e.idx), 64'(udp_tx_data), 64'(e.val));
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge tx_clock);
        chk("rst_request", 64'(udp_tx_request), 64'd0);
        chk("rst_active", 64'(udp_tx_active), 64'd0);
        chk("rst_sync", 64'(sending_sync), 64'd0);
        chk("rst_data", 64'(udp_tx_data), 64'd0);
        chk("rst_acks", 64'({discovery_ACK, erase_ACK, send_more_ACK}), 64'd0);
        chk("rst_length", 64'(udp_tx_length), 64'd60);
        reset_n = 1'b1;
        @(negedge tx_clock);

        // Discovery, run = 0.
        push_pkt(K_DISC, 32'h0, 1'b0, 60);
        discovery_reply = 1'b1;
        @(negedge tx_clock);
        chk("disc_ack", 64'(discovery_ACK), 64'd1);
        chk("disc_other_acks", 64'({erase_ACK, send_more_ACK}), 64'd0);
        @(negedge tx_clock);
        chk("disc_ack_pulse", 64'(discovery_ACK), 64'd0);
        discovery_reply = 1'b0;
        serve("disc", 3, 60, -1, -1);

        // send_more: sequence captured on the edge, later changes ignored.
        sequence_number = 32'h1234_5678;
        push_pkt(K_MORE, 32'h1234_5678, 1'b0, 60);
        send_more = 1'b1;
        @(negedge tx_clock);
        chk("more_ack", 64'(send_more_ACK), 64'd1);
        sequence_number = 32'h0;
        @(negedge tx_clock);
        chk("more_ack_pulse", 64'(send_more_ACK), 64'd0);
        send_more = 1'b0;
        serve("more", 2, 60, -1, -1);

        // erase_done and discovery together: erase goes first.
        sequence_number = 32'hA5A5_0001;
        run = 1'b1;
        push_pkt(K_ERASE, 32'hA5A5_0001, 1'b1, 60);
        push_pkt(K_DISC, 32'h0, 1'b1, 60);
        erase_done      = 1'b1;
        discovery_reply = 1'b1;
        @(negedge tx_clock);
        chk("dual_acks", 64'({discovery_ACK, erase_ACK, send_more_ACK}), 64'b110);
        @(negedge tx_clock);
        erase_done      = 1'b0;
        discovery_reply = 1'b0;
        serve("erase", 1, 60, -1, -1);
        @(negedge tx_clock);
        chk("gap_request", 64'(udp_tx_request), 64'd0);
        chk("gap_sync", 64'(sending_sync), 64'd0);
        serve("disc_run", 0, 60, -1, -1);

        // Grant never arrives.
        discovery_reply = 1'b1;
        @(negedge tx_clock);
        @(negedge tx_clock);
        discovery_reply = 1'b0;
        cnt = 0;
        while (!udp_tx_request && cnt < 20) begin
            @(negedge tx_clock);
            cnt++;
        end
        chk("tmo_req", 64'(udp_tx_request), 64'd1);
        cnt = 0;
        while (udp_tx_request && cnt < 100) begin
            cnt++;
            @(negedge tx_clock);
        end
        chk("tmo_len", 64'(cnt), 64'(TMO));
        chk("tmo_sync", 64'(sending_sync), 64'd0);
        quiet("tmo_no_retry", 6);

        // Grant dropped after byte 20, then a fresh discovery.
        push_pkt(K_DISC, 32'h0, 1'b1, 21);
        discovery_reply = 1'b1;
        @(negedge tx_clock);
        @(negedge tx_clock);
        discovery_reply = 1'b0;
        serve("abort", 2, 21, 21, -1);
        quiet("abort_no_retry", 8);
        push_pkt(K_DISC, 32'h0, 1'b1, 60);
        discovery_reply = 1'b1;
        @(negedge tx_clock);
        @(negedge tx_clock);
        discovery_reply = 1'b0;
        serve("after_abort", 1, 60, -1, -1);

        // Reset mid-packet, then discovery with skew fields.
        push_pkt(K_DISC, 32'h0, 1'b1, 30);
        discovery_reply = 1'b1;
        @(negedge tx_clock);
        @(negedge tx_clock);
        discovery_reply = 1'b0;
        serve("rst", 1, 30, -1, 30);
        repeat (2) @(negedge tx_clock);
        reset_n = 1'b1;
        quiet("rst_no_residual", 10);
        skew_rxtxc     = 8'h67;
        skew_rxtxd     = 8'h46;
        skew_rxtxclk21 = 11'h0EF;
        phaseval       = 8'hF0;
        push_pkt(K_DISC, 32'h0, 1'b1, 60);
        discovery_reply = 1'b1;
        @(negedge tx_clock);
        chk("skew_disc_ack", 64'(discovery_ACK), 64'd1);
        @(negedge tx_clock);
        discovery_reply = 1'b0;
        serve("skew", 1, 60, -1, -1);

        repeat (3) @(negedge tx_clock);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
